// File: rtl/banco_reg_pkg.sv
// Constants shared by banco_reg and its write-port arbiter, plus the
// round-robin pointer encoding.
package banco_reg_pkg;
  localparam int LARG_END  = 5;
  localparam int LARG_DADO = 64;
  localparam int NUM_REGS  = 1 << LARG_END;

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;
endpackage

// File: rtl/arbitro_escrita_banco_reg_placar.sv
// placar_reg: scoreboard of registers with a pending write. Decode sets a
// bit when it reserves a destination; the committed write clears it. A set
// and a clear of the same register on one edge leaves it set, because the
// reservation belongs to a newer instruction. x0 is never tracked.
module placar_reg #(
  parameter int NUM_REGS = 32,
  parameter int LARG_END = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                set_en,
  input  logic [LARG_END-1:0] set_reg,
  input  logic                clr_en,
  input  logic [LARG_END-1:0] clr_reg,
  output logic [NUM_REGS-1:0] ocupado
);
  logic [NUM_REGS-1:0] ocupado_q, ocupado_d;

  // next state: clear first, then set so a new reservation wins
  always_comb begin
    ocupado_d = ocupado_q;
    if (clr_en) ocupado_d[clr_reg] = 1'b0;
    if (set_en) ocupado_d[set_reg] = 1'b1;
    ocupado_d[0] = 1'b0;
  end

  // scoreboard register
  always_ff @(posedge clk) begin
    if (reset) ocupado_q <= '0;
    else       ocupado_q <= ocupado_d;
  end

  assign ocupado = ocupado_q;
endmodule

// File: rtl/arbitro_escrita_banco_reg.sv
// arbitro_escrita_banco_reg: shares the single banco_reg write port between
// writeback requesters A (ALU) and B (load). Round-robin grant, registered
// write drive, pending-destination scoreboard for decode.
// Optional: ARBITRO_ESTAT_EN adds handshake / conflict counters.
module arbitro_escrita_banco_reg #(
  parameter int NUM_REGS  = banco_reg_pkg::NUM_REGS,
  parameter int LARG_END  = banco_reg_pkg::LARG_END,
  parameter int LARG_DADO = banco_reg_pkg::LARG_DADO
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  output logic                 a_ready,
  input  logic [LARG_END-1:0]  a_regd,
  input  logic [LARG_DADO-1:0] a_din,
  input  logic                 b_valid,
  output logic                 b_ready,
  input  logic [LARG_END-1:0]  b_regd,
  input  logic [LARG_DADO-1:0] b_din,
  input  logic                 reserva_valid,
  input  logic [LARG_END-1:0]  reserva_reg,
  output logic [NUM_REGS-1:0]  ocupado,
`ifdef ARBITRO_ESTAT_EN
  output logic [31:0]          cont_a,
  output logic [31:0]          cont_b,
  output logic [31:0]          cont_conflito,
`endif
  output logic                 permisao_escrita,
  output logic [LARG_END-1:0]  regd,
  output logic [LARG_DADO-1:0] din
);
  import banco_reg_pkg::*;

  prio_e                ptr_q, ptr_d;
  logic                 grant_a, grant_b;
  logic [LARG_END-1:0]  win_regd;
  logic [LARG_DADO-1:0] win_din;
  logic                 perm_q, perm_d;
  logic [LARG_END-1:0]  regd_q, regd_d;
  logic [LARG_DADO-1:0] din_q, din_d;

  // grant: lone requester wins, pointer breaks ties; nothing during reset
  always_comb begin
    grant_a = !reset && a_valid && (!b_valid || (ptr_q == PRIO_A));
    grant_b = !reset && b_valid && !grant_a;
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;

  // pointer moves past whoever was just served; holds when idle
  always_comb begin
    ptr_d = ptr_q;
    if (grant_a)      ptr_d = PRIO_B;
    else if (grant_b) ptr_d = PRIO_A;
  end

  // output stage next state; x0 writes are handshaken but never driven
  always_comb begin
    win_regd = grant_a ? a_regd : b_regd;
    win_din  = grant_a ? a_din  : b_din;
    perm_d   = (grant_a || grant_b) && (win_regd != '0);
    regd_d   = perm_d ? win_regd : regd_q;
    din_d    = perm_d ? win_din  : din_q;
  end

  // pointer and output stage registers; reset drops any in-flight write
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q  <= PRIO_A;
      perm_q <= 1'b0;
      regd_q <= '0;
      din_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      perm_q <= perm_d;
      regd_q <= regd_d;
      din_q  <= din_d;
    end
  end

  assign permisao_escrita = perm_q;
  assign regd             = regd_q;
  assign din              = din_q;

  // a write clears its scoreboard bit on the edge banco_reg commits it
  placar_reg #(
    .NUM_REGS (NUM_REGS),
    .LARG_END (LARG_END)
  ) u_placar (
    .clk     (clk),
    .reset   (reset),
    .set_en  (reserva_valid),
    .set_reg (reserva_reg),
    .clr_en  (perm_q),
    .clr_reg (regd_q),
    .ocupado (ocupado)
  );

`ifdef ARBITRO_ESTAT_EN
  logic [31:0] cont_a_q, cont_a_d;
  logic [31:0] cont_b_q, cont_b_d;
  logic [31:0] cont_conf_q, cont_conf_d;

  // counters wrap naturally at 2^32
  always_comb begin
    cont_a_d    = cont_a_q    + 32'(grant_a);
    cont_b_d    = cont_b_q    + 32'(grant_b);
    cont_conf_d = cont_conf_q + 32'(a_valid && b_valid);
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      cont_a_q    <= '0;
      cont_b_q    <= '0;
      cont_conf_q <= '0;
    end else begin
      cont_a_q    <= cont_a_d;
      cont_b_q    <= cont_b_d;
      cont_conf_q <= cont_conf_d;
    end
  end

  assign cont_a        = cont_a_q;
  assign cont_b        = cont_b_q;
  assign cont_conflito = cont_conf_q;
`endif
endmodule

// File: tb/tb_arbitro_escrita_banco_reg.sv
// Bench for arbitro_escrita_banco_reg: directed vector table, hand-written
// scoreboard corner cases, then random traffic against a behavioural model.
module tb_arbitro_escrita_banco_reg;
  import banco_reg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, a_ready, b_ready;
  logic [4:0]  a_regd, b_regd, reserva_reg, regd;
  logic [63:0] a_din, b_din, din;
  logic        reserva_valid, permisao_escrita;
  logic [31:0] ocupado;
`ifdef ARBITRO_ESTAT_EN
  logic [31:0] cont_a, cont_b, cont_conflito;
`endif

  always #5 clk = ~clk;

  arbitro_escrita_banco_reg dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_regd(a_regd), .a_din(a_din),
    .b_valid(b_valid), .b_ready(b_ready), .b_regd(b_regd), .b_din(b_din),
    .reserva_valid(reserva_valid), .reserva_reg(reserva_reg),
    .ocupado(ocupado),
`ifdef ARBITRO_ESTAT_EN
    .cont_a(cont_a), .cont_b(cont_b), .cont_conflito(cont_conflito),
`endif
    .permisao_escrita(permisao_escrita), .regd(regd), .din(din)
  );

  // banco_reg stand-in: reg i starts at i, x0 hardwired to 0
  logic [63:0] mem [32];
  bit          mem_ok = 1'b0;
  always @(posedge clk) begin
    if (!mem_ok) begin
      for (int i = 0; i < 32; i++) mem[i] <= 64'(i);
      mem_ok <= 1'b1;
    end else if (permisao_escrita && regd != 5'd0) begin
      mem[regd] <= din;
    end
  end

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // behavioural model: who has priority, the write in flight, pending set
  bit          m_prio_a;
  bit          m_pv;
  logic [4:0]  m_preg;
  logic [63:0] m_pdin;
  logic [31:0] m_occ;
  logic [31:0] m_ca, m_cb, m_cc;
  bit          got_a, got_b;

  // one clock: check handshake, take the edge, check registered outputs
  task automatic step();
    bit ga, gb;
    logic [4:0] wreg;
    logic [63:0] wdin;
    #1;
    ga = !reset && a_valid && (!b_valid || m_prio_a);
    gb = !reset && b_valid && !ga;
    check("a_ready", 64'(a_ready), 64'(ga));
    check("b_ready", 64'(b_ready), 64'(gb));
    got_a = a_ready;
    got_b = b_ready;
    @(posedge clk);
    if (reset) begin
      m_prio_a = 1; m_pv = 0; m_preg = 0; m_pdin = 0; m_occ = 0;
      m_ca = 0; m_cb = 0; m_cc = 0;
    end else begin
      if (m_pv) m_occ[m_preg] = 1'b0;
      if (reserva_valid && reserva_reg != 0) m_occ[reserva_reg] = 1'b1;
      if (a_valid && b_valid) m_cc++;
      if (ga) m_ca++;
      if (gb) m_cb++;
      if (ga || gb) m_prio_a = gb;
      wreg = ga ? a_regd : b_regd;
      wdin = ga ? a_din : b_din;
      m_pv = (ga || gb) && wreg != 0;
      if (m_pv) begin m_preg = wreg; m_pdin = wdin; end
    end
    #1;
    check("permisao_escrita", 64'(permisao_escrita), 64'(m_pv));
    check("ocupado", 64'(ocupado), 64'(m_occ));
    if (m_pv || reset) begin
      check("regd", 64'(regd), 64'(m_preg));
      check("din", din, m_pdin);
    end
`ifdef ARBITRO_ESTAT_EN
    check("cont_a", 64'(cont_a), 64'(m_ca));
    check("cont_b", 64'(cont_b), 64'(m_cb));
    check("cont_conflito", 64'(cont_conflito), 64'(m_cc));
`endif
  endtask

  typedef struct {
    bit rst; bit av; logic [4:0] ar; logic [63:0] ad;
    bit bv; logic [4:0] br; logic [63:0] bd; bit rv; logic [4:0] rr;
    bit e_ar; bit e_br; bit e_perm; bit e_chk; logic [4:0] e_regd; logic [63:0] e_din;
  } vec_t;

  function automatic vec_t mk(bit rst, bit av, int ar, int ad, bit bv, int br, int bd,
                              bit rv, int rr, bit e_ar, bit e_br, bit e_perm, bit e_chk,
                              int e_regd, int e_din);
    vec_t v;
    v.rst = rst; v.av = av; v.ar = 5'(ar); v.ad = 64'(ad);
    v.bv = bv; v.br = 5'(br); v.bd = 64'(bd); v.rv = rv; v.rr = 5'(rr);
    v.e_ar = e_ar; v.e_br = e_br; v.e_perm = e_perm; v.e_chk = e_chk;
    v.e_regd = 5'(e_regd); v.e_din = 64'(e_din);
    return v;
  endfunction

  task automatic idle();
    a_valid = 0; b_valid = 0; reserva_valid = 0; reset = 0;
  endtask

  vec_t tbl [11];

  initial begin
    //           rst av ar ad  bv br bd  rv rr  ear ebr eperm echk regd din
    tbl[0]  = mk(1, 1, 1, 1,   1, 2, 2,  0, 0,  0, 0, 0, 1, 0,  0);
    tbl[1]  = mk(1, 1, 1, 1,   1, 2, 2,  0, 0,  0, 0, 0, 1, 0,  0);
    tbl[2]  = mk(0, 1, 5, 15,  1, 6, 18, 0, 0,  1, 0, 1, 1, 5,  15);
    tbl[3]  = mk(0, 1, 7, 21,  1, 6, 18, 0, 0,  0, 1, 1, 1, 6,  18);
    tbl[4]  = mk(0, 1, 7, 21,  1, 8, 24, 0, 0,  1, 0, 1, 1, 7,  21);
    tbl[5]  = mk(0, 1, 9, 27,  1, 8, 24, 0, 0,  0, 1, 1, 1, 8,  24);
    tbl[6]  = mk(0, 1, 9, 27,  0, 0, 0,  0, 0,  1, 0, 1, 1, 9,  27);
    tbl[7]  = mk(0, 1, 3, 9,   0, 0, 0,  0, 0,  1, 0, 1, 1, 3,  9);
    tbl[8]  = mk(0, 0, 0, 0,   0, 0, 0,  0, 0,  0, 0, 0, 0, 0,  0);
    tbl[9]  = mk(0, 1, 0, 77,  0, 0, 0,  0, 0,  1, 0, 0, 0, 0,  0);
    tbl[10] = mk(0, 0, 0, 0,   0, 0, 0,  1, 0,  0, 0, 0, 0, 0,  0);

    m_prio_a = 1; m_pv = 0; m_preg = 0; m_pdin = 0; m_occ = 0;
    m_ca = 0; m_cb = 0; m_cc = 0;
    idle(); reset = 1; a_regd = 0; b_regd = 0; a_din = 0; b_din = 0; reserva_reg = 0;

    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst; a_valid = tbl[i].av; a_regd = tbl[i].ar; a_din = tbl[i].ad;
      b_valid = tbl[i].bv; b_regd = tbl[i].br; b_din = tbl[i].bd;
      reserva_valid = tbl[i].rv; reserva_reg = tbl[i].rr;
      if (i == 7) check("mem3_before", mem[3], 64'd3);
      step();
      check("tbl_a_ready", 64'(got_a), 64'(tbl[i].e_ar));
      check("tbl_b_ready", 64'(got_b), 64'(tbl[i].e_br));
      check("tbl_perm", 64'(permisao_escrita), 64'(tbl[i].e_perm));
      if (tbl[i].e_chk) begin
        check("tbl_regd", 64'(regd), 64'(tbl[i].e_regd));
        check("tbl_din", din, tbl[i].e_din);
      end
`ifdef ARBITRO_ESTAT_EN
      if (i == 5) begin
        check("scn3_cont_a", 64'(cont_a), 64'd2);
        check("scn3_cont_b", 64'(cont_b), 64'd2);
        check("scn3_cont_conflito", 64'(cont_conflito), 64'd4);
      end
`endif
    end
    check("mem3_after", mem[3], 64'd9);
    for (int i = 5; i <= 8; i++) check("mem_rr", mem[i], 64'(3 * i));
    check("mem0", mem[0], 64'd0);
    check("ocupado0", 64'(ocupado[0]), 64'd0);

    // scoreboard: set, set-wins against a same-edge commit, then clear
    idle(); reserva_valid = 1; reserva_reg = 12; step();
    check("occ12_set", 64'(ocupado[12]), 64'd1);
    idle(); b_valid = 1; b_regd = 12; b_din = 64'd100; step();
    check("b12_ready", 64'(got_b), 64'd1);
    idle(); reserva_valid = 1; reserva_reg = 12;
    check("perm_12_inflight", 64'(permisao_escrita), 64'd1);
    step();
    check("occ12_setwins", 64'(ocupado[12]), 64'd1);
    idle(); b_valid = 1; b_regd = 12; b_din = 64'd101; step();
    idle(); step();
    check("occ12_cleared", 64'(ocupado[12]), 64'd0);
    check("mem12", mem[12], 64'd101);

    // reset mid-stream returns everything, counters included, to zero
    idle(); a_valid = 1; a_regd = 4; a_din = 64'd44; reset = 1; step();
`ifdef ARBITRO_ESTAT_EN
    check("rst_cont_a", 64'(cont_a), 64'd0);
    check("rst_cont_b", 64'(cont_b), 64'd0);
    check("rst_cont_conflito", 64'(cont_conflito), 64'd0);
`endif
    reset = 0;

    // random traffic; requesters hold their request until accepted
    got_a = 0; got_b = 0;
    for (int c = 0; c < 600; c++) begin
      if (!a_valid || got_a) begin
        a_valid = ($urandom_range(2) != 0);
        a_regd = 5'($urandom_range(7));
        a_din = {$urandom, $urandom};
      end
      if (!b_valid || got_b) begin
        b_valid = ($urandom_range(2) != 0);
        b_regd = 5'($urandom_range(7));
        b_din = {$urandom, $urandom};
      end
      reserva_valid = ($urandom_range(1) != 0);
      reserva_reg = 5'($urandom_range(7));
      reset = ($urandom_range(49) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/arbitro_escrita_banco_reg.md
Name: arbitro_escrita_banco_reg

Overview:
Shares the single write port of banco_reg (32 x 64-bit, 2 read / 1 write) between two writeback requesters: A (ALU) and B (memory load).
- Round-robin arbitration with a valid/ready handshake.
- Registered drive of permisao_escrita/regd/din.
- Scoreboard of pending destination registers, used by decode for hazard stalls.
- Sits between the writeback stage and banco_reg.

Parameters:
- NUM_REGS, 32, number of architectural registers (must equal 2**LARG_END)
- LARG_END, 5, register index width
- LARG_DADO, 64, data width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A's write accepted this cycle
- a_regd  in  LARG_END  A destination register
- a_din  in  LARG_DADO  A write data
- b_valid, b_ready, b_regd, b_din  same as A, for requester B
- reserva_valid  in  1  decode reserves a destination register
- reserva_reg  in  LARG_END  register being reserved
- ocupado  out  NUM_REGS  bit i = 1 while register i has a pending write
- permisao_escrita  out  1  to banco_reg write enable
- regd  out  LARG_END  to banco_reg write address
- din  out  LARG_DADO  to banco_reg write data

Behaviour:
- Reset, sampled at posedge with reset=1:
  - permisao_escrita=0, regd=0, din=0, ocupado=0.
  - Priority pointer set to A.
  - Reset mid-operation discards any in-flight write; the write is not performed.
- Arbitration is combinational in the current cycle:
  - Only A valid -> grant A. Only B valid -> grant B.
  - Both valid -> grant the requester indicated by the pointer.
  - a_ready = a_valid & grant_A; b_ready likewise. Never both 1.
  - Requesters hold valid/regd/din stable until ready.
- Pointer update: on any grant, the pointer moves to the other requester. With no grant it holds.
- Output stage (1-cycle latency):
  - Grant at edge N: at edge N the stage registers regd/din and permisao_escrita=1; banco_reg commits at edge N+1.
  - No grant: permisao_escrita=0; regd/din hold their previous values.
  - The stage always drains (banco_reg accepts every cycle), so no backpressure beyond arbitration.
- Register x0:
  - A granted write with regd=0 is handshaken (ready=1).
  - It is dropped: permisao_escrita stays 0.
  - ocupado[0] is always 0; reservations of x0 are ignored.
- Scoreboard:
  - reserva_valid at edge sets ocupado[reserva_reg].
  - A committed write (permisao_escrita=1 at edge) clears ocupado[regd].
  - Same register reserved and cleared at the same edge -> stays 1 (new reservation wins).
  - Reserving an already-set bit keeps it 1. No counting of multiple outstanding writes to the same register.
- No internal FSM beyond the pointer (states PRIO_A, PRIO_B) and the output valid bit.

Optional Feature:
- Macro: ARBITRO_ESTAT_EN.
- Defined:
  - Adds outputs cont_a and cont_b, 32 bits each: count accepted handshakes per requester, including x0 writes.
  - Adds output cont_conflito, 32 bits: counts cycles with a_valid & b_valid.
  - All three reset to 0 and wrap modulo 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package banco_reg_pkg: LARG_END, LARG_DADO, NUM_REGS, and the PRIO_A/PRIO_B pointer encoding.
  - banco_reg and this block use the same constants.
- One natural sub-module: placar_reg, the scoreboard with set/clear ports and set-wins rule, NUM_REGS-bit register.
- Arbitration and the output stage stay in the top.

Test Plan:
1. Reset held 2 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0 during reset. After release: permisao_escrita=0, ocupado=0, first grant goes to A.
2. A only: regd=3, din=9 -> a_ready=1 same cycle, then permisao_escrita=1, regd=3, din=9 for exactly one cycle. banco_reg read of reg 3 returns 9 afterwards (was 3).
3. A and B both valid for 4 cycles with distinct regs 5..8 -> grants A,B,A,B. Each requester sees ready on alternate cycles. banco_reg ends with reg i = 3*i for i=5..8.
4. a_regd=0, din=77 -> a_ready=1, permisao_escrita stays 0, reg 0 still reads 0. reserva_reg=0 leaves ocupado[0]=0.
5. Reserve reg 12 -> ocupado[12]=1. Then issue reserve 12 and have B's earlier write to 12 commit at the same edge -> ocupado[12] remains 1. Next commit to 12 without a reserve -> ocupado[12]=0.
6. With ARBITRO_ESTAT_EN: run scenario 3 -> cont_a=2, cont_b=2, cont_conflito=4. Apply reset -> all three 0.
